csr_timer: RTL and testbench

- Constant-frequency countdown timer: owns the TCFG and TVAL CSRs and raises the timer interrupt flag TI.
- Consumes TICLR clear writes; it is the producer side of the TVAL/TI path that the interrupt-clear logic observes.
- Sits in the system-register block alongside the other CSRs.
- Feeds `ti` to the ESTAT.IS[11] pending-interrupt logic and exposes TCFG/TVAL/TICLR values to the CSR read mux.

---
 rtl/csr_timer_if.sv | 26 ++
 rtl/csr_timer.sv | 104 ++++++++++
 tb/tb_csr_timer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_timer_if.sv
// CSR-side bundle for csr_timer: write strobes/data from the CSR unit and the
// read values / interrupt flag returned by the timer.
interface csr_timer_if;
  logic        tcfg_we;
  logic [31:0] tcfg_wdata;
  logic        ticlr_we;
  logic [31:0] ticlr_wdata;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic [31:0] ticlr;
  logic        ti;
  logic [31:0] tid;
  logic [63:0] stable_cnt;

  // CSR unit side
  modport master (
    output tcfg_we, tcfg_wdata, ticlr_we, ticlr_wdata,
    input  tcfg, tval, ticlr, ti, tid, stable_cnt
  );

  // Timer side
  modport slave (
    input  tcfg_we, tcfg_wdata, ticlr_we, ticlr_wdata,
    output tcfg, tval, ticlr, ti, tid, stable_cnt
  );
endinterface

// File: rtl/csr_timer.sv
// Constant-frequency countdown timer owning TCFG/TVAL/TICLR and the sticky TI flag.
// Optional feature macro TIMER_STABLE_CNT_EN: when defined, adds a free-running
// 64-bit stable counter and a TID register; otherwise both outputs read 0.
module csr_timer #(
  parameter int unsigned TIMER_N = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input logic       clk,
  input logic       rst_n,
  csr_timer_if.slave bus
);

  localparam logic [TIMER_N-1:0] CntOne = TIMER_N'(1);

  logic [TIMER_N-1:0] tcfg_q, tcfg_d;
  logic [TIMER_N-1:0] tval_q, tval_d;
  logic               ti_q, ti_d;
  logic               set_evt;
  logic               clr_req;
  logic [TIMER_N-1:0] reload_val;

  // Next-state for config, count and interrupt flag
  always_comb begin
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    ti_d       = ti_q;
    reload_val = {tcfg_q[TIMER_N-1:2], 2'b00};
    // A TCFG write on the same edge suppresses the set event.
    set_evt    = !bus.tcfg_we && tcfg_q[0] && (tval_q == CntOne);
    clr_req    = bus.ticlr_we && bus.ticlr_wdata[0];

    if (bus.tcfg_we) begin
      tcfg_d = bus.tcfg_wdata[TIMER_N-1:0];
      tval_d = {bus.tcfg_wdata[TIMER_N-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d = tval_q - CntOne;
      end else if (tcfg_q[1]) begin
        tval_d = reload_val;
      end
    end

    // Set beats clear so a coincident clear never loses an interrupt.
    if (set_evt) begin
      ti_d = 1'b1;
    end else if (clr_req) begin
      ti_d = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcfg_q <= '0;
      tval_q <= '1;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign bus.tcfg  = 32'(tcfg_q);
  assign bus.tval  = 32'(tval_q);
  assign bus.ticlr = 32'h0;
  assign bus.ti    = ti_q;

`ifdef TIMER_STABLE_CNT_EN
  logic [63:0] stable_cnt_q;
  logic [31:0] tid_q;

  // Free-running stable counter, wraps naturally at 2^64
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt_q <= '0;
    end else begin
      stable_cnt_q <= stable_cnt_q + 64'd1;
    end
  end

  // Timer ID register; read-only from this block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q <= TID_RST;
    end else begin
      tid_q <= tid_q;
    end
  end

  assign bus.stable_cnt = stable_cnt_q;
  assign bus.tid        = tid_q;

  logic unused_bits;
  assign unused_bits = ^{bus.tcfg_wdata, bus.ticlr_wdata[31:1]};
`else
  assign bus.stable_cnt = 64'h0;
  assign bus.tid        = 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.tcfg_wdata, bus.ticlr_wdata[31:1], TID_RST};
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: an elapsed-cycle model checked every cycle,
// plus hand-computed literal checks along the test plan.
module tb_csr_timer;
  localparam int unsigned TimerN = 32;
  localparam logic [31:0] TidRst = 32'h0000_00A5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  csr_timer_if bus ();

  csr_timer #(
    .TIMER_N (TimerN),
    .TID_RST (TidRst)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: load value + enabled cycles elapsed since load ----------
  longint unsigned m_load, m_k, m_sc;
  bit              m_en, m_per, m_ti;
  logic [31:0]     m_tcfg;

  function automatic longint unsigned model_tval(input longint unsigned l,
                                                 input longint unsigned k, input bit per);
    if (l == 0) return 0;
    if (per) return l - (k % (l + 1));
    return (k >= l) ? 0 : l - k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 64'hFFFF_FFFF;
      m_k    <= 0;
      m_en   <= 1'b0;
      m_per  <= 1'b0;
      m_ti   <= 1'b0;
      m_tcfg <= 32'h0;
      m_sc   <= 0;
    end else begin
      longint unsigned cur;
      bit set;
      cur = model_tval(m_load, m_k, m_per);
      set = !bus.tcfg_we && m_en && (cur == 1);
      if (bus.tcfg_we) begin
        m_tcfg <= bus.tcfg_wdata;
        m_load <= longint'(bus.tcfg_wdata & 32'hFFFF_FFFC);
        m_k    <= 0;
        m_en   <= bus.tcfg_wdata[0];
        m_per  <= bus.tcfg_wdata[1];
      end else if (m_en) begin
        m_k <= m_k + 1;
      end
      if (set) m_ti <= 1'b1;
      else if (bus.ticlr_we && bus.ticlr_wdata[0]) m_ti <= 1'b0;
      m_sc <= m_sc + 1;
    end
  end

  // Compare process: outputs are registered, so sample at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tval", bus.tval, model_tval(m_load, m_k, m_per));
      chk("ti", bus.ti, m_ti);
      chk("tcfg", bus.tcfg, m_tcfg);
      chk("ticlr", bus.ticlr, 0);
`ifdef TIMER_STABLE_CNT_EN
      chk("stable_cnt", bus.stable_cnt, m_sc);
      chk("tid", bus.tid, TidRst);
`else
      chk("stable_cnt", bus.stable_cnt, 0);
      chk("tid", bus.tid, 0);
`endif
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_tcfg(input logic [31:0] d);
    bus.tcfg_we = 1'b1;
    bus.tcfg_wdata = d;
    @(negedge clk);
    bus.tcfg_we = 1'b0;
    bus.tcfg_wdata = 32'h0;
  endtask

  task automatic wr_ticlr(input logic [31:0] d);
    bus.ticlr_we = 1'b1;
    bus.ticlr_wdata = d;
    @(negedge clk);
    bus.ticlr_we = 1'b0;
    bus.ticlr_wdata = 32'h0;
  endtask

  initial begin
    bus.tcfg_we = 1'b0;
    bus.tcfg_wdata = 32'h0;
    bus.ticlr_we = 1'b0;
    bus.ticlr_wdata = 32'h0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    chk("rst tval", bus.tval, 32'hFFFF_FFFF);
    chk("rst ti", bus.ti, 0);
    chk("rst tcfg", bus.tcfg, 0);
    step(2);
    chk("rst hold tval", bus.tval, 32'hFFFF_FFFF);

    // 1: one-shot InitVal=4
    wr_tcfg(32'h0000_0011);
    chk("t1 load", bus.tval, 16);
    step(15);
    chk("t1 at1 tval", bus.tval, 1);
    chk("t1 at1 ti", bus.ti, 0);
    step(1);
    chk("t1 zero tval", bus.tval, 0);
    chk("t1 zero ti", bus.ti, 1);
    step(3);
    chk("t1 hold tval", bus.tval, 0);

    // 3: TICLR behaviour
    wr_ticlr(32'hFFFF_FFFE);
    chk("t3 noclr ti", bus.ti, 1);
    wr_ticlr(32'h0000_0001);
    chk("t3 clr ti", bus.ti, 0);
    chk("t3 ticlr rd", bus.ticlr, 0);
    step(3);
    chk("t3 sticky ti", bus.ti, 0);

    // 2: periodic InitVal=2
    wr_tcfg(32'h0000_000B);
    chk("t2 load", bus.tval, 8);
    step(7);
    chk("t2 at1", bus.tval, 1);
    step(1);
    chk("t2 zero tval", bus.tval, 0);
    chk("t2 zero ti", bus.ti, 1);
    step(1);
    chk("t2 reload", bus.tval, 8);
    step(8);
    chk("t2 period", bus.tval, 0);
    step(1);

    // 4: set wins over coincident clear
    wr_ticlr(32'h1);
    chk("t4 pre clr", bus.ti, 0);
    chk("t4 tval7", bus.tval, 7);
    step(6);
    chk("t4 at1", bus.tval, 1);
    wr_ticlr(32'h1);
    chk("t4 set wins", bus.ti, 1);
    wr_ticlr(32'h1);
    chk("t4 clr after", bus.ti, 0);
    chk("t4 reload", bus.tval, 8);

    // 5: disable mid-count
    step(3);
    chk("t5 at5", bus.tval, 5);
    wr_tcfg(32'h0000_000C);
    chk("t5 frozen load", bus.tval, 12);
    step(3);
    chk("t5 frozen", bus.tval, 12);
    chk("t5 ti", bus.ti, 0);
    wr_tcfg(32'h0000_000D);
    step(1);
    chk("t5 resume", bus.tval, 11);
    // write on the would-be set edge: write wins, no ti
    step(10);
    chk("t5 at1", bus.tval, 1);
    wr_tcfg(32'h0000_000D);
    chk("wr wins tval", bus.tval, 12);
    chk("wr wins ti", bus.ti, 0);
    // loading 0 directly never sets ti, one-shot and periodic
    wr_tcfg(32'h0000_0001);
    step(3);
    chk("load0 ti", bus.ti, 0);
    wr_tcfg(32'h0000_0003);
    step(3);
    chk("per0 tval", bus.tval, 0);
    chk("per0 ti", bus.ti, 0);

    // 6: async reset while counting with ti=1
    wr_tcfg(32'h0000_0005);
    step(4);
    chk("t6 ti set", bus.ti, 1);
    wr_tcfg(32'h0000_000B);
    chk("t6 wr keeps ti", bus.ti, 1);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst tval", bus.tval, 32'hFFFF_FFFF);
    chk("t6 rst ti", bus.ti, 0);
    chk("t6 rst tcfg", bus.tcfg, 0);
    chk("t6 rst sc", bus.stable_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
`ifdef TIMER_STABLE_CNT_EN
    chk("t6 sc1", bus.stable_cnt, 1);
    step(1);
    chk("t6 sc2", bus.stable_cnt, 2);
`else
    chk("t6 sc1", bus.stable_cnt, 0);
    step(1);
    chk("t6 sc2", bus.stable_cnt, 0);
`endif
    step(3);
    chk("t6 no count", bus.tval, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
